// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS PC fetch path
// Purpose: PC width, reset/exception vector defaults, fetch FSM state type
//          and the next-PC select encoding shared by the fetch unit and its mux.
// Ports:   none (package).
package mips_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'h8000_0180;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_JR   = 3'd1,
    SEL_TRAP = 3'd2,
    SEL_J    = 3'd3,
    SEL_BR   = 3'd4,
    SEL_SEQ  = 3'd5
  } next_pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control/fetch bundle between datapath control and the PC unit
// Purpose: groups the next-PC control inputs and the fetch outputs.
// Ports (modports):
//   master - control side: drives stall/branch/jump/jr controls, observes fetch outputs.
//   slave  - fetch unit:   receives controls, drives pc, pc_plus4, fetch_valid,
//                          misalign, fetch_count.
interface pc_fetch_unit_if;
  import mips_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic            jump;
  logic [27:0]     jump_addr;
  logic            jump_reg;
  logic [PC_W-1:0] reg_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            fetch_valid;
  logic            misalign;
  logic [PC_W-1:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_addr, jump_reg, reg_target,
    input  pc, pc_plus4, fetch_valid, misalign, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_addr, jump_reg, reg_target,
    output pc, pc_plus4, fetch_valid, misalign, fetch_count
  );

endinterface

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - priority next-PC select and target arithmetic
// Purpose: picks the next PC source (hold > jr/trap > j > branch > sequential)
//          and computes its value. Purely combinational.
// Ports:
//   i_run           fetch FSM is in RUN (BOOT forces hold)
//   i_stall         hold request
//   i_jump_reg      jr selected, i_reg_target its target
//   i_jump          j/jal selected, i_jump_addr shifted 28-bit field
//   i_branch_taken  branch taken, i_branch_offset unshifted sign-extended imm
//   i_pc, i_pc_plus4 current PC and PC+4
//   o_sel           chosen source, o_next_pc its value
module next_pc_mux
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic            i_run,
  input  logic            i_stall,
  input  logic            i_jump_reg,
  input  logic [PC_W-1:0] i_reg_target,
  input  logic            i_jump,
  input  logic [27:0]     i_jump_addr,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_offset,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_pc_plus4,
  output next_pc_sel_t    o_sel,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_jump_target;
  logic [PC_W-1:0] w_branch_target;

  // Low two bits of the jump field are forced to zero so the target is
  // always word aligned even if the upstream shifter hands us garbage there.
  assign w_jump_target   = {i_pc_plus4[31:28], i_jump_addr} & ~32'h3;
  assign w_branch_target = i_pc_plus4 + (i_branch_offset << 2);

  always_comb begin
    o_sel = SEL_HOLD;
    if (!i_run || i_stall) begin
      o_sel = SEL_HOLD;
    end else if (i_jump_reg) begin
      o_sel = (i_reg_target[1:0] == 2'b00) ? SEL_JR : SEL_TRAP;
    end else if (i_jump) begin
      o_sel = SEL_J;
    end else if (i_branch_taken) begin
      o_sel = SEL_BR;
    end else begin
      o_sel = SEL_SEQ;
    end
  end

  always_comb begin
    o_next_pc = i_pc;
    case (o_sel)
      SEL_HOLD: o_next_pc = i_pc;
      SEL_JR:   o_next_pc = i_reg_target;
      SEL_TRAP: o_next_pc = EXC_VECTOR;
      SEL_J:    o_next_pc = w_jump_target;
      SEL_BR:   o_next_pc = w_branch_target;
      SEL_SEQ:  o_next_pc = i_pc_plus4;
      default:  o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, boot cycle, stall hold, jr trap and fetch counter
// Purpose: holds the PC and drives the instruction-memory address each cycle.
//          One BOOT cycle after reset, then RUN with priority next-PC selection.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pc_fetch_unit_if.slave: control inputs in; pc, pc_plus4,
//          fetch_valid, misalign, fetch_count out
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [PC_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.slave   bus
);

  pc_state_t       r_state;
  pc_state_t       w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_fetch_count;
  logic            r_misalign;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_next_pc;
  next_pc_sel_t    w_sel;
  logic            w_fetch_valid;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_fetch_valid = 1'b0;
    case (r_state)
      BOOT:    w_fetch_valid = 1'b0;
      RUN:     w_fetch_valid = 1'b1;
      default: w_fetch_valid = 1'b0;
    endcase
  end

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_mux #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_pc_mux (
    .i_run           (r_state == RUN),
    .i_stall         (bus.stall),
    .i_jump_reg      (bus.jump_reg),
    .i_reg_target    (bus.reg_target),
    .i_jump          (bus.jump),
    .i_jump_addr     (bus.jump_addr),
    .i_branch_taken  (bus.branch_taken),
    .i_branch_offset (bus.branch_offset),
    .i_pc            (r_pc),
    .i_pc_plus4      (w_pc_plus4),
    .o_sel           (w_sel),
    .o_next_pc       (w_next_pc)
  );

  // Every non-hold select is a retired fetch, traps included; the misalign
  // flop is rewritten each cycle so it naturally pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc       <= w_next_pc;
      r_misalign <= (w_sel == SEL_TRAP);
      if (w_sel != SEL_HOLD) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;
  assign bus.fetch_valid = w_fetch_valid;
  assign bus.misalign    = r_misalign;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t q[$];

  pc_fetch_unit_if u_if ();

  pc_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "pc",          u_if.pc,                  e.pc);
      chk(e.name, "pc_plus4",    u_if.pc_plus4,            e.pc + 32'd4);
      chk(e.name, "fetch_valid", {31'd0, u_if.fetch_valid}, {31'd0, e.fv});
      chk(e.name, "misalign",    {31'd0, u_if.misalign},    {31'd0, e.mis});
      chk(e.name, "fetch_count", u_if.fetch_count,         e.cnt);
    end
  end

  // Drive one cycle of inputs, then push the state expected after that edge.
  task automatic cyc(input string nm, input logic rn, input logic st,
                     input logic br, input logic [31:0] off,
                     input logic j, input logic [27:0] ja,
                     input logic jr, input logic [31:0] rt,
                     input logic [31:0] e_pc, input logic e_fv,
                     input logic e_mis, input logic [31:0] e_cnt);
    exp_t e;
    rst_n              = rn;
    u_if.stall         = st;
    u_if.branch_taken  = br;
    u_if.branch_offset = off;
    u_if.jump          = j;
    u_if.jump_addr     = ja;
    u_if.jump_reg      = jr;
    u_if.reg_target    = rt;
    @(posedge clk);
    #1;
    e.name = nm; e.pc = e_pc; e.fv = e_fv; e.mis = e_mis; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  initial begin
    int waited;
    total = 0;
    bad   = 0;
    //     name        rn st br off           j  ja          jr rt            pc            fv mis cnt
    cyc("rst0",        0, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0000, 0, 0, 0);
    cyc("rst1",        0, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0000, 0, 0, 0);
    cyc("boot",        1, 0, 0, 32'h0,        1, 28'h0000400, 0, 32'h0,       32'h0000_0000, 1, 0, 0);
    cyc("seq4",        1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0004, 1, 0, 1);
    cyc("seq8",        1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0008, 1, 0, 2);
    cyc("seqC",        1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_000C, 1, 0, 3);
    cyc("jr_setup",    1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h1000_0010, 32'h1000_0010, 1, 0, 4);
    cyc("jump",        1, 0, 0, 32'h0,        1, 28'h0000400, 0, 32'h0,       32'h1000_0400, 1, 0, 5);
    cyc("jr_100",      1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h0000_0100, 32'h0000_0100, 1, 0, 6);
    cyc("br_neg",      1, 0, 1, 32'hFFFF_FFFE, 0, 28'h0,     0, 32'h0,        32'h0000_00FC, 1, 0, 7);
    cyc("jr_top",      1, 0, 0, 32'h0,        0, 28'h0,      1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 0, 8);
    cyc("br_wrap",     1, 0, 1, 32'h0000_0001, 0, 28'h0,     0, 32'h0,        32'h0000_0000, 1, 0, 9);
    cyc("jr_fffc",     1, 0, 0, 32'h0,        0, 28'h0,      1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 10);
    cyc("seq_wrap",    1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0000, 1, 0, 11);
    cyc("trap",        1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h0040_0021, 32'h8000_0180, 1, 1, 12);
    cyc("after_trap",  1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h8000_0184, 1, 0, 13);
    cyc("jr_ok",       1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h0040_0020, 32'h0040_0020, 1, 0, 14);
    cyc("j_over_br",   1, 0, 1, 32'h0000_0005, 1, 28'h0000123, 0, 32'h0,      32'h0000_0120, 1, 0, 15);
    cyc("jr_over_j",   1, 0, 0, 32'h0,        1, 28'h0000400, 1, 32'h0000_0200, 32'h0000_0200, 1, 0, 16);
    cyc("stall1",      1, 1, 0, 32'h0,        1, 28'h0000800, 0, 32'h0,       32'h0000_0200, 1, 0, 16);
    cyc("stall2_jr",   1, 1, 0, 32'h0,        1, 28'h0000800, 1, 32'h0000_0003, 32'h0000_0200, 1, 0, 16);
    cyc("stall3",      1, 1, 0, 32'h0,        1, 28'h0000800, 0, 32'h0,       32'h0000_0200, 1, 0, 16);
    cyc("unstall_j",   1, 0, 0, 32'h0,        1, 28'h0000800, 0, 32'h0,       32'h0000_0800, 1, 0, 17);
    cyc("trap2",       1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h0040_0021, 32'h8000_0180, 1, 1, 18);
    cyc("mid_rst",     0, 1, 0, 32'h0,        0, 28'h0,      1, 32'h0040_0021, 32'h0000_0000, 0, 0, 0);
    cyc("boot2",       1, 0, 0, 32'h0,        0, 28'h0,      1, 32'h0040_0021, 32'h0000_0000, 1, 0, 0);
    cyc("seq4_again",  1, 0, 0, 32'h0,        0, 28'h0,      0, 32'h0,        32'h0000_0004, 1, 0, 1);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter register and next-PC selector for the single-cycle MIPS datapath.
- Sits directly downstream of the jump-address shift-left-two stage: consumes its 28-bit shifted jump field, plus the branch offset, the jr register value and the control decisions.
- Drives the instruction-memory address every cycle.
- Adds a boot cycle, stall hold, misaligned-jr trap and a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC loaded on a misaligned jr target.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- stall  in  1  hold PC and counter this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  32  sign-extended 16-bit immediate (unshifted).
- jump  in  1  j/jal selected.
- jump_addr  in  28  shifted jump field, {instr[25:0],2'b00}.
- jump_reg  in  1  jr selected.
- reg_target  in  32  rs value for jr.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, combinational, for link register / branch base.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- misalign  out  1  one-cycle pulse: jr target not word aligned.
- fetch_count  out  32  number of PC advances since reset.

Behaviour:
Reset (rst_n low at a rising edge), which wins over everything:
- pc=RESET_PC, state=BOOT, fetch_valid=0, misalign=0, fetch_count=0.

BOOT state:
- Lasts exactly one cycle.
- fetch_valid=0; pc holds; control inputs ignored.
- Next state is RUN.

RUN state:
- fetch_valid=1.
- Next PC selection priority, highest first:
  1. stall: pc holds, fetch_count holds, misalign=0.
  2. jump_reg:
     - If reg_target[1:0]==0: pc<=reg_target.
     - Else: pc<=EXC_VECTOR and misalign=1 for the following cycle only.
  3. jump: pc<={pc_plus4[31:28], jump_addr[27:2], 2'b00}. jump_addr[1:0] is ignored (forced 0).
  4. branch_taken: pc<=pc_plus4 + (branch_offset<<2), truncated to 32 bits.
  5. otherwise: pc<=pc_plus4.

Arithmetic:
- All adds are modulo 2^32. pc=32'hFFFF_FFFC sequential wraps to 0.
- A branch with a negative offset wraps likewise.

Counter:
- fetch_count increments by 1 on every RUN cycle without stall, including jumps and traps.
- Wraps from 32'hFFFF_FFFF to 0.

Simultaneous assertions:
- Resolved strictly by the priority above. Example: jump and branch_taken both high gives the jump target.

Outputs and output timing:
- pc_plus4 = pc + 4 combinationally at all times, including BOOT.
- misalign is registered; it is never asserted in BOOT or while stall is high.
- A trap takes effect on the same edge as a normal jr (latency 1).

Reset mid-operation:
- Next edge with rst_n low returns to BOOT regardless of stall or pending trap.
- A pending misalign pulse is cleared.

Decomposition:
- Shared package mips_pkg:
  - PC width constant (32).
  - RESET_PC / EXC_VECTOR defaults.
  - 1-bit state typedef pc_state_t {BOOT, RUN}.
  - Next-PC select encoding enum {SEL_HOLD, SEL_JR, SEL_TRAP, SEL_J, SEL_BR, SEL_SEQ}.
- One sub-module, next_pc_mux:
  - Combinational priority select and target arithmetic.
  - Produces the select code and next-PC value.
- Top module holds the state register, pc register, misalign flop and counter.

Test Plan:
- Reset then 4 free cycles:
  - Cycle after reset: pc=0, fetch_valid=0.
  - Then pc=0,4,8 with fetch_valid=1.
  - fetch_count=2 after pc reaches 8.
- Jump at pc=32'h1000_0010 with jump_addr=28'h0000_400 -> pc=32'h1000_0400, fetch_count +1.
- Branch at pc=32'h0000_0100, branch_offset=32'hFFFF_FFFE -> pc=32'h0000_00FC. Same at pc=32'hFFFF_FFF8, offset=1 -> pc=32'h0000_0000.
- jr with reg_target=32'h0040_0021:
  - pc=32'h8000_0180, misalign=1 for exactly one cycle.
  - jr with 32'h0040_0020 -> pc=32'h0040_0020, misalign=0.
- stall high 3 cycles alongside jump=1:
  - pc and fetch_count unchanged.
  - Jump applied on the first cycle stall drops.
- rst_n low for one cycle mid-run with jump_reg and a misaligned target asserted:
  - Next cycle pc=RESET_PC, fetch_valid=0, misalign=0, fetch_count=0.
